// File: rtl/mdu_issue_queue.sv
// Compacting, age-ordered issue queue for multiply/divide micro-ops.
// Entry 0 is the oldest; valid entries always occupy indices 0..count-1.
// Each cycle the oldest op with both sources ready is issued through a
// registered output stage, unless it is a divide and the divider is busy.
module mdu_issue_queue #(
   parameter int DEPTH  = 8,
   parameter int PREG_W = 6,
   parameter int ROB_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_back,
   input  logic                  disp_valid,
   input  logic [PREG_W-1:0]     disp_Pa,
   input  logic [PREG_W-1:0]     disp_Pb,
   input  logic                  disp_rdyA,
   input  logic                  disp_rdyB,
   input  logic [PREG_W-1:0]     disp_Pd,
   input  logic                  disp_RegWr,
   input  logic [3:0]            disp_Conf,
   input  logic [ROB_W-1:0]      disp_tag_rob,
   output logic                  full,
   input  logic [1:0]            wake_valid,
   input  logic [2*PREG_W-1:0]   wake_Pd,
   input  logic                  div_busy,
   output logic                  iss_ready,
   output logic [PREG_W-1:0]     iss_Pa,
   output logic [PREG_W-1:0]     iss_Pb,
   output logic [PREG_W-1:0]     iss_Pd,
   output logic                  iss_RegWr,
   output logic [3:0]            iss_Conf,
   output logic [ROB_W-1:0]      iss_tag_rob
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // MDU op configuration encoding
   localparam logic [3:0] MUL_CONF    = 4'h0;
   localparam logic [3:0] MULH_CONF   = 4'h1;
   localparam logic [3:0] MULHSU_CONF = 4'h2;
   localparam logic [3:0] MULHU_CONF  = 4'h3;
   localparam logic [3:0] DIV_CONF    = 4'h4;
   localparam logic [3:0] DIVU_CONF   = 4'h5;
   localparam logic [3:0] MOD_CONF    = 4'h6;
   localparam logic [3:0] MODU_CONF   = 4'h7;

   typedef struct packed {
      logic [PREG_W-1:0] pa;
      logic [PREG_W-1:0] pb;
      logic              rdya;
      logic              rdyb;
      logic [PREG_W-1:0] pd;
      logic              regwr;
      logic [3:0]        conf;
      logic [ROB_W-1:0]  rob;
   } entry_t;

   typedef struct packed {
      logic              ready;
      logic [PREG_W-1:0] pa;
      logic [PREG_W-1:0] pb;
      logic [PREG_W-1:0] pd;
      logic              regwr;
      logic [3:0]        conf;
      logic [ROB_W-1:0]  rob;
   } issue_t;

   // True when either broadcast port carries the given tag
   function automatic logic wake_hit(input logic [PREG_W-1:0]   tag,
                                     input logic [1:0]          vld,
                                     input logic [2*PREG_W-1:0] tags);
      wake_hit = (vld[0] && (tags[0 +: PREG_W] == tag)) ||
                 (vld[1] && (tags[PREG_W +: PREG_W] == tag));
   endfunction

   function automatic logic is_div(input logic [3:0] conf);
      is_div = (conf == DIV_CONF) || (conf == DIVU_CONF) ||
               (conf == MOD_CONF) || (conf == MODU_CONF);
   endfunction

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   issue_t           iss_q, iss_d;

   logic [DEPTH-1:0] rdya_w;     // ready bits including this cycle's wakeups
   logic [DEPTH-1:0] rdyb_w;
   logic [DEPTH-1:0] elig;       // evaluated from registered ready bits only
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic             disp_acc;
   logic [CNT_W-1:0] wr_pos;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign disp_acc = disp_valid && !full;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign rdya_w[gi] = ent_q[gi].rdya || wake_hit(ent_q[gi].pa, wake_valid, wake_Pd);
         assign rdyb_w[gi] = ent_q[gi].rdyb || wake_hit(ent_q[gi].pb, wake_valid, wake_Pd);
         assign elig[gi]   = (CNT_W'(gi) < count_q) && ent_q[gi].rdya && ent_q[gi].rdyb &&
                             !(is_div(ent_q[gi].conf) && div_busy);
      end
   endgenerate

   // Oldest-first select: scan from the top so the lowest eligible index wins
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

   // Next-state: wakeup, compaction above the issued slot, dispatch write, flush
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i]      = ent_q[i];
         ent_d[i].rdya = rdya_w[i];
         ent_d[i].rdyb = rdyb_w[i];
      end
      count_d = count_q;
      iss_d   = '0;
      wr_pos  = count_q - CNT_W'(sel_found);

      if (sel_found) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (IDX_W'(i) >= sel_idx) begin
               if (i < DEPTH - 1) begin
                  ent_d[i]      = ent_q[IDX_W'(i + 1)];
                  ent_d[i].rdya = rdya_w[IDX_W'(i + 1)];
                  ent_d[i].rdyb = rdyb_w[IDX_W'(i + 1)];
               end else begin
                  ent_d[i] = '0;
               end
            end
         end
         iss_d.ready = 1'b1;
         iss_d.pa    = ent_q[sel_idx].pa;
         iss_d.pb    = ent_q[sel_idx].pb;
         iss_d.pd    = ent_q[sel_idx].pd;
         iss_d.regwr = ent_q[sel_idx].regwr;
         iss_d.conf  = ent_q[sel_idx].conf;
         iss_d.rob   = ent_q[sel_idx].rob;
      end

      if (disp_acc) begin
         ent_d[wr_pos[IDX_W-1:0]].pa    = disp_Pa;
         ent_d[wr_pos[IDX_W-1:0]].pb    = disp_Pb;
         ent_d[wr_pos[IDX_W-1:0]].rdya  = disp_rdyA || wake_hit(disp_Pa, wake_valid, wake_Pd);
         ent_d[wr_pos[IDX_W-1:0]].rdyb  = disp_rdyB || wake_hit(disp_Pb, wake_valid, wake_Pd);
         ent_d[wr_pos[IDX_W-1:0]].pd    = disp_Pd;
         ent_d[wr_pos[IDX_W-1:0]].regwr = disp_RegWr;
         ent_d[wr_pos[IDX_W-1:0]].conf  = disp_Conf;
         ent_d[wr_pos[IDX_W-1:0]].rob   = disp_tag_rob;
      end

      count_d = count_q + CNT_W'(disp_acc) - CNT_W'(sel_found);

      // Flush wins over everything; count = 0 makes every entry invalid
      if (flush_back) begin
         count_d = '0;
         iss_d   = '0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         iss_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         iss_q   <= iss_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

   assign iss_ready   = iss_q.ready;
   assign iss_Pa      = iss_q.pa;
   assign iss_Pb      = iss_q.pb;
   assign iss_Pd      = iss_q.pd;
   assign iss_RegWr   = iss_q.regwr;
   assign iss_Conf    = iss_q.conf;
   assign iss_tag_rob = iss_q.rob;

endmodule
